mc_ctrl_fsm: RTL and testbench

//  Multi-cycle control sequencer for the MIPS datapath. Decodes the registered
//  IR opcode/funct and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/mc_ctrl_fsm.sv | 222 ++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with
// illegal-instruction and memory-timeout fault detection.
module mc_ctrl_fsm #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             m4,
    output logic             ext_sign,
    output logic [2:0]       alu_op,
    output logic             rf_we,
    output logic             rf_dst_sel,
    output logic             rf_wdata_sel,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Wait counter spans 0..TIMEOUT-1; the last value is the final accepted cycle
    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [2:0]        state;
    logic [2:0]        state_n;
    logic [WAIT_W-1:0] wcnt;
    logic              retire_c;
    logic              illegal_c;
    logic              timeout_c;
    logic              r_legal_c;
    logic              op_legal_c;
    logic [2:0]        r_alu_c;

    // R-type funct decode
    always_comb begin
        r_legal_c = 1'b1;
        r_alu_c   = 3'd0;
        case (funct)
            6'h20, 6'h21: r_alu_c = 3'd0;
            6'h22, 6'h23: r_alu_c = 3'd1;
            6'h24:        r_alu_c = 3'd2;
            6'h25:        r_alu_c = 3'd3;
            6'h26:        r_alu_c = 3'd4;
            6'h27:        r_alu_c = 3'd5;
            6'h2A:        r_alu_c = 3'd6;
            6'h2B:        r_alu_c = 3'd7;
            default:      r_legal_c = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_R:                          op_legal_c = r_legal_c;
            OP_J, OP_BEQ, OP_ADDI, OP_ADDIU,
            OP_ANDI, OP_ORI, OP_LW, OP_SW: op_legal_c = 1'b1;
            default:                       op_legal_c = 1'b0;
        endcase
    end

    // Next state and strobes
    always_comb begin
        state_n      = state;
        retire_c     = 1'b0;
        illegal_c    = 1'b0;
        timeout_c    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        m4           = 1'b0;
        ext_sign     = 1'b0;
        alu_op       = 3'd0;
        rf_we        = 1'b0;
        rf_dst_sel   = 1'b0;
        rf_wdata_sel = 1'b0;
        case (state)
            S_IDLE: state_n = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_n = S_DECODE;
                end else if (wcnt == WAIT_LAST) begin
                    timeout_c = 1'b1;
                    state_n   = S_FAULT;
                end
            end
            S_DECODE: begin
                if (!op_legal_c) begin
                    illegal_c = 1'b1;
                    state_n   = S_FAULT;
                end else if (opcode == OP_J) begin
                    pc_we    = 1'b1;
                    pc_src   = 2'd2;
                    retire_c = 1'b1;
                    state_n  = S_FETCH;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                state_n = S_WB;
                case (opcode)
                    OP_R: alu_op = r_alu_c;
                    OP_ADDI, OP_ADDIU: begin
                        m4       = 1'b1;
                        ext_sign = 1'b1;
                    end
                    OP_ANDI: begin
                        m4     = 1'b1;
                        alu_op = 3'd2;
                    end
                    OP_ORI: begin
                        m4     = 1'b1;
                        alu_op = 3'd3;
                    end
                    OP_LW, OP_SW: begin
                        m4       = 1'b1;
                        ext_sign = 1'b1;
                        state_n  = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op   = 3'd1;
                        pc_we    = alu_zero;
                        pc_src   = 2'd1;
                        retire_c = 1'b1;
                        state_n  = S_FETCH;
                    end
                    default: state_n = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire_c = 1'b1;
                        state_n  = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (wcnt == WAIT_LAST) begin
                    timeout_c = 1'b1;
                    state_n   = S_FAULT;
                end
            end
            S_WB: begin
                rf_we        = 1'b1;
                rf_dst_sel   = (opcode == OP_R);
                rf_wdata_sel = (opcode == OP_LW);
                retire_c     = 1'b1;
                state_n      = S_FETCH;
            end
            S_FAULT: state_n = S_FAULT;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            retired    <= '0;
            fault      <= 1'b0;
            fault_code <= 2'd0;
        end else begin
            state <= state_n;
            // Counter restarts whenever a new state is entered
            if (state_n != state) begin
                wcnt <= '0;
            end else if (state == S_FETCH || state == S_MEM) begin
                wcnt <= wcnt + WAIT_W'(1);
            end
            if (retire_c) begin
                retired <= retired + CNT_W'(1);
            end
            if (illegal_c) begin
                fault      <= 1'b1;
                fault_code <= 2'd1;
            end else if (timeout_c) begin
                fault      <= 1'b1;
                fault_code <= 2'd2;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: an instruction-level model pushes the
// expected per-cycle control word; a monitor pops and compares at negedge.
module tb_mc_ctrl_fsm;

    localparam int unsigned TMO = 16;

    typedef struct packed {
        logic [2:0]  st;
        logic        mem_req;
        logic        mem_we;
        logic        mem_addr_sel;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pc_src;
        logic        m4;
        logic        ext_sign;
        logic [2:0]  alu_op;
        logic        rf_we;
        logic        rf_dst_sel;
        logic        rf_wdata_sel;
        logic [31:0] retired;
        logic        fault;
        logic [1:0]  fault_code;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode, funct;
    logic        alu_zero, mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0]  pc_src;
    logic        m4, ext_sign;
    logic [2:0]  alu_op;
    logic        rf_we, rf_dst_sel, rf_wdata_sel;
    logic [2:0]  state_o;
    logic [31:0] retired;
    logic        fault;
    logic [1:0]  fault_code;

    mc_ctrl_fsm #(.TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .m4(m4), .ext_sign(ext_sign),
        .alu_op(alu_op), .rf_we(rf_we), .rf_dst_sel(rf_dst_sel),
        .rf_wdata_sel(rf_wdata_sel), .state_o(state_o), .retired(retired),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    obs_t        q[$];
    obs_t        e_mon, a_mon;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          started = 0;

    // Reference model state
    int unsigned m_ret = 0;
    bit          m_fault = 0;
    logic [1:0]  m_code = 2'd0;

    logic [5:0] ops[9] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    logic [5:0] rfn[10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    // Monitor: one expected control word per cycle
    initial begin
        forever begin
            @(negedge clk);
            if (started && q.size() != 0) begin
                e_mon = q.pop_front();
                a_mon = {state_o, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
                         m4, ext_sign, alu_op, rf_we, rf_dst_sel, rf_wdata_sel,
                         retired, fault, fault_code};
                n_cmp++;
                if (a_mon !== e_mon) begin
                    n_bad++;
                    $display("FAIL ctrl_word t=%0t state act=%0d exp=%0d word act=%h exp=%h",
                             $time, a_mon.st, e_mon.st, a_mon, e_mon);
                end
            end
        end
    end

    // Directed point check
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: return (fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2A || fn == 6'h2B;
            6'h02, 6'h04, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h23, 6'h2B: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        if (fn < 6'h24) return 3'((fn - 6'h20) >> 1);
        if (fn <= 6'h27) return 3'(fn - 6'h22);
        return 3'(fn - 6'h24);
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t o;
        o            = '0;
        o.st         = st;
        o.retired    = m_ret;
        o.fault      = m_fault;
        o.fault_code = m_code;
        return o;
    endfunction

    task automatic cyc(input obs_t o);
        q.push_back(o);
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_inputs();
        mem_ready = 1'($urandom_range(0, 1));
        alu_zero  = 1'($urandom_range(0, 1));
    endtask

    // One memory access (fetch or data); ok=0 on timeout or reset abort
    task automatic mem_phase(input bit is_mem, input logic [5:0] op, input int wt,
                             input bit abort, output bit ok);
        obs_t o;
        bit   rdy;
        ok = 1'b0;
        for (int k = 1; k <= int'(TMO); k++) begin
            rdy       = (k == wt + 1);
            mem_ready = rdy;
            alu_zero  = 1'($urandom_range(0, 1));
            o = base(is_mem ? 3'd4 : 3'd1);
            o.mem_req      = 1'b1;
            o.mem_addr_sel = is_mem;
            o.mem_we       = is_mem && (op == 6'h2B);
            if (!is_mem && rdy) begin
                o.ir_we = 1'b1;
                o.pc_we = 1'b1;
            end
            if (abort) begin
                rst_n     = 1'b0;
                mem_ready = 1'b0;
                cyc(o);
                m_ret = 0;
                rst_n = 1'b1;
                cyc(base(3'd0));
                return;
            end
            cyc(o);
            if (rdy) begin
                ok = 1'b1;
                return;
            end
        end
        m_fault = 1'b1;
        m_code  = 2'd2;
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input bit zero,
                            input int fw, input int mw, input bit abort);
        obs_t o;
        bit   ok;
        opcode = op;
        funct  = fn;
        mem_phase(1'b0, op, fw, 1'b0, ok);
        if (!ok) return;
        rnd_inputs();
        o = base(3'd2);
        if (!legal(op, fn)) begin
            cyc(o);
            m_fault = 1'b1;
            m_code  = 2'd1;
            return;
        end
        if (op == 6'h02) begin
            o.pc_we  = 1'b1;
            o.pc_src = 2'd2;
            cyc(o);
            m_ret++;
            return;
        end
        cyc(o);
        rnd_inputs();
        alu_zero = zero;
        o = base(3'd3);
        case (op)
            6'h00: o.alu_op = r_alu(fn);
            6'h08, 6'h09, 6'h23, 6'h2B: begin o.m4 = 1'b1; o.ext_sign = 1'b1; end
            6'h0C: begin o.m4 = 1'b1; o.alu_op = 3'd2; end
            6'h0D: begin o.m4 = 1'b1; o.alu_op = 3'd3; end
            default: begin o.alu_op = 3'd1; o.pc_we = zero; o.pc_src = 2'd1; end
        endcase
        cyc(o);
        if (op == 6'h04) begin
            m_ret++;
            return;
        end
        if (op == 6'h23 || op == 6'h2B) begin
            mem_phase(1'b1, op, mw, abort, ok);
            if (!ok) return;
            if (op == 6'h2B) begin
                m_ret++;
                return;
            end
        end
        rnd_inputs();
        o = base(3'd5);
        o.rf_we        = 1'b1;
        o.rf_dst_sel   = (op == 6'h00);
        o.rf_wdata_sel = (op == 6'h23);
        cyc(o);
        m_ret++;
    endtask

    task automatic hold_fault(input int n);
        for (int i = 0; i < n; i++) begin
            rnd_inputs();
            cyc(base(3'd7));
        end
    endtask

    task automatic do_reset(input obs_t cur);
        rst_n = 1'b0;
        rnd_inputs();
        cyc(cur);
        m_ret   = 0;
        m_fault = 1'b0;
        m_code  = 2'd0;
        rst_n   = 1'b1;
        cyc(base(3'd0));
    endtask

    task automatic chk_timeout();
        chk("timeout_state", 32'(state_o), 32'd7);
        chk("timeout_fault", 32'(fault), 32'd1);
        chk("timeout_code", 32'(fault_code), 32'd2);
        chk("timeout_mem_req", 32'(mem_req), 32'd0);
    endtask

    task automatic chk_illegal();
        chk("illegal_state", 32'(state_o), 32'd7);
        chk("illegal_code", 32'(fault_code), 32'd1);
        chk("illegal_rf_we", 32'(rf_we), 32'd0);
        chk("illegal_pc_we", 32'(pc_we), 32'd0);
    endtask

    initial begin
        logic [5:0] op, fn;
        rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; alu_zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_retired", retired, 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_fault_code", 32'(fault_code), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_pc_we", 32'(pc_we), 32'd0);
        rst_n   = 1'b1;
        started = 1'b1;
        cyc(base(3'd0));

        do_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
        do_instr(6'h0D, 6'h11, 1'b0, 0, 0, 1'b0);
        do_instr(6'h23, 6'h05, 1'b0, 0, 0, 1'b0);
        do_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);
        do_instr(6'h04, 6'h00, 1'b0, 0, 0, 1'b0);
        do_instr(6'h02, 6'h3F, 1'b0, 0, 0, 1'b0);
        do_instr(6'h2B, 6'h00, 1'b0, 0, 15, 1'b0);
        do_instr(6'h08, 6'h00, 1'b0, 15, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            op = ops[$urandom_range(0, 8)];
            fn = (op == 6'h00) ? rfn[$urandom_range(0, 9)] : 6'($urandom_range(0, 63));
            do_instr(op, fn, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2)),
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2)),
                     1'b0);
        end

        do_instr(6'h23, 6'h00, 1'b0, 0, 0, 1'b1);
        do_instr(6'h09, 6'h00, 1'b0, 1, 0, 1'b0);
        do_instr(6'h0C, 6'h00, 1'b0, 0, 0, 1'b0);

        do_instr(6'h3F, 6'h20, 1'b0, 0, 0, 1'b0);
        chk_illegal();
        hold_fault(4);
        do_reset(base(3'd7));
        do_instr(6'h00, 6'h00, 1'b0, 0, 0, 1'b0);
        chk_illegal();
        hold_fault(4);
        do_reset(base(3'd7));
        do_instr(6'h00, 6'h2A, 1'b0, 0, 0, 1'b0);
        do_instr(6'h2B, 6'h00, 1'b0, 0, 16, 1'b0);
        chk_timeout();
        hold_fault(5);
        chk_timeout();
        do_reset(base(3'd7));
        do_instr(6'h0D, 6'h00, 1'b0, 16, 0, 1'b0);
        chk_timeout();
        hold_fault(3);
        do_reset(base(3'd7));
        do_instr(6'h00, 6'h27, 1'b0, 0, 0, 1'b0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
